i2c_wr_master: RTL
==================

// Module: i2c_wr_master
// PURPOSE
//  Open-drain I2C write master that sends one 3-byte write: address byte {DEV_ADDR,1'b0},
//  then data_i[15:8], then data_i[7:0]. It reports slave ACK status for each write.
//  It sits directly downstream of the codec configuration sequencer, which issues one
//  16-bit {reg[6:0],val[8:0]} word per transaction to the audio codec.
//  It runs entirely on the system clock. SCL timing comes from an internal quarter-period tick.
// PARAMETERS
//  CLK_DIV   42     clk cycles per SCL quarter-period (>=2); SCL period = 4*CLK_DIV clk
//  DEV_ADDR  7'h1A  7-bit slave address (codec write byte = 8'h34)
// PORTS
//  clk          in     1   system clock
//  rst          in     1   asynchronous active-high reset
//  start_i      in     1   request; sampled only while busy_o=0
//  data_i       in     16  word to send; captured in the cycle start_i is accepted
//  busy_o       out    1   high from the cycle after acceptance until the done_o cycle (exclusive)
//  done_o       out    1   one-cycle pulse at the end of a transaction
//  ack_ok_o     out    1   1 = all three bytes ACKed in the last transaction; valid from done_o
//  i2c_sclk_o   out    1   SCL, push-pull
//  i2c_sdat_io  inout  1   SDA, open-drain: drives 1'b0 or 1'bz, never 1'b1
// BEHAVIOUR
//  Reset (asynchronous, immediate): FSM=IDLE, busy_o=0, done_o=0, ack_ok_o=0,
//   i2c_sclk_o=1, SDA released (z), tick counter=0, shift reg=0.
//  Tick: counter runs 0..CLK_DIV-1 only while busy_o=1 and is cleared in IDLE.
//   One quarter elapses at each wrap. Each slot has 4 quarters, q0..q3.
//  FSM states: IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> IDLE.
//   IDLE: SCL=1, SDA=z. If start_i=1: latch {DEV_ADDR,0,data_i} into 24b shift reg,
//    byte_cnt=0, bit_cnt=7, go to START. busy_o=1 from the next cycle.
//   START slot: q0,q1 SCL=1 SDA=z; q2 SCL=1 SDA=0 (START cond); q3 SCL=0 SDA=0.
//   BIT slot, MSB first: q0 SCL=0, SDA=bit (0 -> drive 0, 1 -> z); q1,q2 SCL=1; q3 SCL=0.
//    After 8 BIT slots, go to ACK.
//   ACK slot: SDA=z in all quarters; SCL as BIT. Sample SDA in the last clk of q2.
//    SDA=0 means ACK. On ACK: if byte_cnt<2, byte_cnt++ and go to BIT; else go to STOP.
//    On NACK (SDA=1 or z): record the failure and go straight to STOP; remaining bytes are skipped.
//   STOP slot: q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2,q3 SCL=1 SDA=z (STOP cond).
//    At the end of q3: go to IDLE, done_o=1 for one cycle, ack_ok_o = no NACK seen.
//  SCL/SDA edges: SDA changes only while SCL=0, except the START and STOP edges.
//  Latency, measured from the acceptance cycle to the done_o cycle:
//   (8 + 36*k)*CLK_DIV clk, where k = bytes sent (1..3).
//   All bytes ACKed: k=3, 116*CLK_DIV. NACK on the address byte: 44*CLK_DIV.
//  start_i while busy_o=1 is ignored and not queued. data_i is don't-care after acceptance.
//  done_o and busy_o=0 occur in the same cycle. A start_i in that cycle is accepted (back-to-back).
//  ack_ok_o holds its value until the next done_o.
//  Reset mid-transaction aborts at once and may leave a truncated frame on the bus.
//   This is accepted: the slave resyncs on the next START.
// TESTING
//  Bench: SDA pullup (tri1) plus a behavioural slave that ACKs address 0x34. CLK_DIV=4.
//  1. start_i with data_i=16'h0C17 -> bus shows START,34,A,0C,A,17,A,STOP;
//     done_o exactly 464 clk after acceptance; ack_ok_o=1.
//  2. Slave disabled, data_i=16'h1201 -> START,34,NACK,STOP; done_o at 176 clk;
//     ack_ok_o=0; no data bits driven.
//  3. Slave NACKs the 2nd data byte -> bytes 34,A,xx,A,yy,N then STOP;
//     done_o at 464 clk; ack_ok_o=0.
//  4. start_i pulsed again at +100 clk with a different word -> ignored;
//     only the first word appears on the bus.
//  5. start_i held high through done_o -> second transaction starts the next cycle;
//     busy_o low for the done cycle only.
//  6. rst=1 mid-byte (+200 clk) -> same cycle: SCL=1, SDA=z, busy_o=0, ack_ok_o=0;
//     no done_o pulse.
//  Checker throughout: SDA never driven 1; SDA stable while SCL=1 except START/STOP.

Source files
------------

// File: rtl/i2c_wr_master.sv
// i2c_wr_master: open-drain I2C write master. Sends one 3-byte write per request:
// {DEV_ADDR,W}, data_i[15:8], data_i[7:0], and reports whether every byte was ACKed.
// SCL is built from a quarter-period tick of CLK_DIV system clocks.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start_i       transaction request, sampled only while idle
//   data_i        16-bit word, captured on acceptance
//   busy_o        transaction in progress
//   done_o        one-cycle end-of-transaction pulse
//   ack_ok_o      all bytes ACKed in the last transaction (valid from done_o)
//   i2c_sclk_o    SCL, push-pull
//   i2c_sdat_io   SDA, open-drain (drives 0 or z only)
module i2c_wr_master #(
    parameter int unsigned CLK_DIV  = 42,
    parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ack_ok_o,
    output logic        i2c_sclk_o,
    inout  wire         i2c_sdat_io
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SR_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              nack_q, nack_d;
    logic              ack_smp_q, ack_smp_d;
    logic              sda_low_q, sda_low_d;
    logic              busy_d, done_d, ack_ok_d, scl_d;
    logic              qtr_wrap, slot_end, stop_end;
    logic              sda_in;

    // Open-drain SDA: only ever pull low or release.
    assign i2c_sdat_io = sda_low_q ? 1'b0 : 1'bz;
    assign sda_in      = i2c_sdat_io;

    assign qtr_wrap = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign slot_end = qtr_wrap && (qtr_q == 2'd3);
    // Leave STOP one clk early so the done/idle cycle completes the last quarter
    // (bus levels in IDLE equal STOP q3).
    assign stop_end = (qtr_q == 2'd3) && (cnt_q == CNT_W'(CLK_DIV - 2));

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            qtr_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            nack_q     <= 1'b0;
            ack_smp_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            ack_ok_o   <= 1'b0;
            i2c_sclk_o <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            nack_q     <= nack_d;
            ack_smp_q  <= ack_smp_d;
            sda_low_q  <= sda_low_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            ack_ok_o   <= ack_ok_d;
            i2c_sclk_o <= scl_d;
        end
    end

    // Next state, tick/quarter sequencing and next-cycle bus levels.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        qtr_d      = qtr_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        nack_d     = nack_q;
        ack_smp_d  = ack_smp_q;
        done_d     = 1'b0;
        ack_ok_d   = ack_ok_o;
        busy_d     = 1'b0;
        scl_d      = 1'b1;
        sda_low_d  = 1'b0;

        if (state_q != S_IDLE) begin
            if (qtr_wrap) begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shift_d    = {DEV_ADDR, 1'b0, data_i};
                    bit_cnt_d  = 3'd7;
                    byte_cnt_d = 2'd0;
                    nack_d     = 1'b0;
                    cnt_d      = '0;
                    qtr_d      = 2'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (slot_end) state_d = S_BIT;
            end
            S_BIT: begin
                if (slot_end) begin
                    shift_d   = {shift_q[SR_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) state_d = S_ACK;
                end
            end
            S_ACK: begin
                // Sample in the last clk of q2, while SCL is high.
                if (qtr_wrap && (qtr_q == 2'd2)) ack_smp_d = ~sda_in;
                if (slot_end) begin
                    if (!ack_smp_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (byte_cnt_q != 2'd2) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = S_BIT;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    qtr_d    = 2'd0;
                    done_d   = 1'b1;
                    ack_ok_d = ~nack_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        // Bus levels for the slot/quarter being entered.
        unique case (state_d)
            S_START: begin
                scl_d     = (qtr_d != 2'd3);
                sda_low_d = (qtr_d >= 2'd2);
            end
            S_BIT: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = ~shift_d[SR_W-1];
            end
            S_ACK: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = 1'b0;
            end
            S_STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = (qtr_d <= 2'd1);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

endmodule
